// File: rtl/move_type_scheduler.sv
// MCMC iteration sequencer: one RNG draw per iteration picks a local or
// global move, dispatches it, and waits for that unit's done before continuing.
module move_type_scheduler #(
  parameter int ITER_W  = 16,
  parameter int PLS_MAX = 100
) (
  input  logic              in_clock,
  input  logic              in_reset_n,
  input  logic              in_start,
  input  logic              in_abort,
  input  logic [ITER_W-1:0] in_num_iters,
  input  logic [7:0]        in_Pls,
  input  logic [7:0]        in_rng_value,
  output logic              out_rng_enable,
  output logic              out_local_start,
  input  logic              in_local_done,
  output logic              out_global_start,
  input  logic              in_global_done,
  output logic              out_busy,
  output logic              out_done,
  output logic              out_is_local,
  output logic [ITER_W-1:0] out_local_count,
  output logic [ITER_W-1:0] out_global_count
);

  localparam logic [7:0] PMAX = 8'(PLS_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAW,
    S_DECIDE,
    S_RUN_L,
    S_RUN_G,
    S_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [ITER_W-1:0] iters_q;
  logic [ITER_W-1:0] idx_q;
  logic [ITER_W-1:0] lcnt_q;
  logic [ITER_W-1:0] gcnt_q;
  logic [7:0]        pls_q;
  logic              is_local_q;
  logic              first_q;

  logic last;
  logic go;
  logic dec;
  logic l_acc;
  logic g_acc;

  assign last  = (idx_q + ITER_W'(1)) == iters_q;
  assign go    = (state_q == S_IDLE) && in_start && !in_abort;
  assign dec   = (state_q == S_DECIDE) && !in_abort;
  assign l_acc = (state_q == S_RUN_L) && in_local_done && !in_abort;
  assign g_acc = (state_q == S_RUN_G) && in_global_done && !in_abort;

  always_ff @(posedge in_clock) begin
    if (!in_reset_n) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (in_abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_start)
            state_d = (in_num_iters == '0) ? S_FINISH : S_DRAW;
        end
        S_DRAW:   state_d = S_DECIDE;
        S_DECIDE: state_d = (in_rng_value <= pls_q) ? S_RUN_L : S_RUN_G;
        S_RUN_L: begin
          if (in_local_done) state_d = last ? S_FINISH : S_DRAW;
        end
        S_RUN_G: begin
          if (in_global_done) state_d = last ? S_FINISH : S_DRAW;
        end
        S_FINISH: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    out_busy         = state_q != S_IDLE;
    out_done         = state_q == S_FINISH;
    out_rng_enable   = state_q == S_DRAW;
    out_local_start  = (state_q == S_RUN_L) && first_q;
    out_global_start = (state_q == S_RUN_G) && first_q;
    out_is_local     = is_local_q;
    out_local_count  = lcnt_q;
    out_global_count = gcnt_q;
  end

  // first_q marks the entry cycle of a RUN state for the start pulse
  always_ff @(posedge in_clock) begin
    if (!in_reset_n) begin
      iters_q    <= '0;
      idx_q      <= '0;
      lcnt_q     <= '0;
      gcnt_q     <= '0;
      pls_q      <= '0;
      is_local_q <= 1'b0;
      first_q    <= 1'b0;
    end else begin
      first_q <= dec;
      if (go) begin
        iters_q <= in_num_iters;
        pls_q   <= (in_Pls > PMAX) ? PMAX : in_Pls;
        idx_q   <= '0;
        lcnt_q  <= '0;
        gcnt_q  <= '0;
      end
      if (dec) is_local_q <= in_rng_value <= pls_q;
      if (l_acc) begin
        lcnt_q <= lcnt_q + ITER_W'(1);
        idx_q  <= idx_q + ITER_W'(1);
      end
      if (g_acc) begin
        gcnt_q <= gcnt_q + ITER_W'(1);
        idx_q  <= idx_q + ITER_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_move_type_scheduler.sv
// Directed bench for move_type_scheduler with an RNG stub and
// delayed done responders for both move units.
module tb_move_type_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, abort;
  logic [15:0] niters;
  logic [7:0]  pls;
  logic [7:0]  rng;
  logic        rng_en, ls, gs, ldone, gdone;
  logic        busy, done, isl;
  logic [15:0] lc, gc;

  logic       auto_l, auto_g, man_l, man_g;
  logic       clr, rng_rst;
  logic [2:0] lp, gp;
  logic [7:0] tab [0:7];
  int         ridx, nrng, ndone, nstart;
  logic [7:0] seq;
  int         tests = 0;
  int         fails = 0;
  int         n;

  move_type_scheduler #(.ITER_W(16), .PLS_MAX(100)) dut (
    .in_clock         (clk),
    .in_reset_n       (rst_n),
    .in_start         (start),
    .in_abort         (abort),
    .in_num_iters     (niters),
    .in_Pls           (pls),
    .in_rng_value     (rng),
    .out_rng_enable   (rng_en),
    .out_local_start  (ls),
    .in_local_done    (ldone),
    .out_global_start (gs),
    .in_global_done   (gdone),
    .out_busy         (busy),
    .out_done         (done),
    .out_is_local     (isl),
    .out_local_count  (lc),
    .out_global_count (gc)
  );

  // each unit answers 3 cycles after its start pulse
  assign ldone = (auto_l & lp[2]) | man_l;
  assign gdone = (auto_g & gp[2]) | man_g;

  always @(posedge clk) begin
    if (!rst_n) begin
      lp <= '0;
      gp <= '0;
    end else begin
      lp <= {lp[1:0], ls};
      gp <= {gp[1:0], gs};
    end
  end

  always @(posedge clk) begin
    if (rng_rst) ridx <= 0;
    else if (rng_en) begin
      rng  <= tab[ridx[2:0]];
      ridx <= ridx + 1;
    end
  end

  always @(posedge clk) begin
    if (clr) begin
      nrng   <= 0;
      ndone  <= 0;
      nstart <= 0;
      seq    <= '0;
    end else begin
      if (rng_en) nrng <= nrng + 1;
      if (done) ndone <= ndone + 1;
      if (ls | gs) begin
        nstart <= nstart + 1;
        seq    <= {seq[6:0], ls};
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic prep;
    clr     = 1'b1;
    rng_rst = 1'b1;
    tick;
    clr     = 1'b0;
    rng_rst = 1'b0;
  endtask

  task automatic run_start(input int it, input int p);
    niters = 16'(it);
    pls    = 8'(p);
    start  = 1'b1;
    tick;
    start  = 1'b0;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 1;
    while (!done && cnt < 300) begin
      tick;
      cnt++;
    end
    if (!done) chk("done_timeout", 32'(cnt), 32'(0));
  endtask

  task automatic wait_start(input int sel);
    int k = 0;
    while (!(sel != 0 ? gs : ls) && k < 100) begin
      tick;
      k++;
    end
    if (k >= 100) chk("start_timeout", 32'(sel), 32'(2));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    niters = '0; pls = '0;
    auto_l = 1'b0; auto_g = 1'b0; man_l = 1'b0; man_g = 1'b0;
    clr = 1'b1; rng_rst = 1'b1;
    for (int i = 0; i < 8; i++) tab[i] = '0;

    // reset
    tick; tick;
    chk("rst_busy",  32'(busy),   0);
    chk("rst_done",  32'(done),   0);
    chk("rst_ls",    32'(ls),     0);
    chk("rst_gs",    32'(gs),     0);
    chk("rst_rng",   32'(rng_en), 0);
    chk("rst_isl",   32'(isl),    0);
    chk("rst_lc",    32'(lc),     0);
    chk("rst_gc",    32'(gc),     0);
    rst_n = 1'b1; clr = 1'b0; rng_rst = 1'b0;
    tick;

    // 4 iterations, Pls 50: draws 10,90,50,51 -> L,G,L,G
    tab[0] = 8'd10; tab[1] = 8'd90; tab[2] = 8'd50; tab[3] = 8'd51;
    auto_l = 1'b1; auto_g = 1'b1;
    prep;
    run_start(4, 50);
    chk("t2_busy", 32'(busy), 1);
    wait_done(n);
    chk("t2_lat", 32'(n), 25);
    chk("t2_lc", 32'(lc), 2);
    chk("t2_gc", 32'(gc), 2);
    tick; tick;
    chk("t2_seq",   32'(seq[3:0]), 32'b1010);
    chk("t2_nst",   32'(nstart), 4);
    chk("t2_nrng",  32'(nrng), 4);
    chk("t2_ndone", 32'(ndone), 1);
    chk("t2_idle",  32'(busy), 0);
    chk("t2_isl",   32'(isl), 0);

    // Pls 200 clamps to 100; draw 100 is local
    for (int i = 0; i < 8; i++) tab[i] = 8'd100;
    prep;
    run_start(3, 200);
    wait_done(n);
    tick;
    chk("t3_lc",  32'(lc), 3);
    chk("t3_gc",  32'(gc), 0);
    chk("t3_isl", 32'(isl), 1);

    // zero iterations
    prep;
    run_start(0, 50);
    chk("t4_done", 32'(done), 1);
    tick;
    chk("t4_busy",  32'(busy), 0);
    chk("t4_nrng",  32'(nrng), 0);
    chk("t4_lc",    32'(lc), 0);
    chk("t4_gc",    32'(gc), 0);
    chk("t4_ndone", 32'(ndone), 1);

    // abort in RUN_G of iteration 2 of 5
    for (int i = 0; i < 8; i++) tab[i] = (i % 2 == 0) ? 8'd10 : 8'd90;
    auto_g = 1'b0;
    prep;
    run_start(5, 50);
    wait_start(1);
    tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_lc",   32'(lc), 1);
    chk("t5_gc",   32'(gc), 0);
    tick;
    man_g = 1'b1;
    tick;
    man_g = 1'b0;
    tick;
    chk("t5_late_gc",   32'(gc), 0);
    chk("t5_late_busy", 32'(busy), 0);
    chk("t5_ndone",     32'(ndone), 0);
    auto_g = 1'b1;
    prep;
    run_start(2, 50);
    chk("t5_clr_lc", 32'(lc), 0);
    chk("t5_clr_gc", 32'(gc), 0);
    wait_done(n);
    tick;
    chk("t5_lc2",    32'(lc), 1);
    chk("t5_gc2",    32'(gc), 1);
    chk("t5_ndone2", 32'(ndone), 1);

    // wrong-unit done, start and Pls/num_iters change mid-run
    tab[0] = 8'd50; tab[1] = 8'd90; tab[2] = 8'd50;
    auto_l = 1'b0; auto_g = 1'b0;
    prep;
    run_start(3, 50);
    pls    = 8'd0;
    niters = 16'd1;
    wait_start(0);
    man_g = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    man_g = 1'b0;
    chk("t6_busy", 32'(busy), 1);
    chk("t6_nrng", 32'(nrng), 1);
    chk("t6_gc",   32'(gc), 0);
    chk("t6_lc",   32'(lc), 0);
    man_l = 1'b1;
    tick;
    man_l = 1'b0;
    chk("t6_lc1", 32'(lc), 1);
    auto_l = 1'b1; auto_g = 1'b1;
    wait_done(n);
    tick;
    chk("t6_lc3",   32'(lc), 2);
    chk("t6_gc3",   32'(gc), 1);
    chk("t6_seq",   32'(seq[2:0]), 32'b101);
    chk("t6_nst",   32'(nstart), 3);
    chk("t6_ndone", 32'(ndone), 1);
    chk("t6_isl",   32'(isl), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/move_type_scheduler.md
# move_type_scheduler

Iteration sequencer for the MCMC solver. It runs a programmed number of iterations. In each iteration it draws one random number from the shared `RandomGenerator` (range 0..100), compares the draw against the local-move probability threshold `Pls`, and dispatches a single move to either the local-move unit or the global-move unit. It waits for that unit's done handshake before starting the next iteration, and keeps per-type move counters for debug and statistics.

## Interface
Parameters:
- `ITER_W`, 16: width of the iteration count and the move counters.
- `PLS_MAX`, 100: upper bound of the RNG range. A captured `Pls` above this value is clamped to it.

Ports:
- `in_clock`, input, 1: system clock, rising edge.
- `in_reset_n`, input, 1: reset, synchronous, active-low.
- `in_start`, input, 1: start a run. Sampled only in IDLE.
- `in_abort`, input, 1: abandon the run. Returns to IDLE on the next edge.
- `in_num_iters`, input, `ITER_W`: number of iterations. Captured at start.
- `in_Pls`, input, 8: local-move threshold, 0..255. Captured at start.
- `in_rng_value`, input, 8: registered output of the RNG.
- `out_rng_enable`, output, 1: advance the RNG by one value.
- `out_local_start`, output, 1: one-cycle pulse that launches a local move.
- `in_local_done`, input, 1: local move finished.
- `out_global_start`, output, 1: one-cycle pulse that launches a global move.
- `in_global_done`, input, 1: global move finished.
- `out_busy`, output, 1: high in every state except IDLE.
- `out_done`, output, 1: one-cycle pulse when the run completes.
- `out_is_local`, output, 1: decision of the most recent iteration.
- `out_local_count`, output, `ITER_W`: local moves completed in the current run.
- `out_global_count`, output, `ITER_W`: global moves completed in the current run.

## Operation
States:
- **IDLE**
  - `in_start`=1: capture `num_iters` and `pls = min(in_Pls, PLS_MAX)`; clear both counters and the iteration index.
  - If `num_iters`==0, go to FINISH. Otherwise go to DRAW.
- **DRAW**: `out_rng_enable`=1 for exactly this cycle. Go to DECIDE.
- **DECIDE**
  - The RNG value is valid in this cycle. Decision is local when `in_rng_value <= pls`, compared as unsigned 8-bit.
  - Register `out_is_local`.
  - Go to RUN_L if local, otherwise RUN_G.
- **RUN_L / RUN_G**
  - The matching start pulse is high in the first cycle of the state only.
  - Wait for the matching done signal. The non-matching done signal is ignored.
  - On done: increment the matching counter and the iteration index. If the index reaches `num_iters`, go to FINISH; otherwise go to DRAW.
- **FINISH**: `out_done`=1 for one cycle. Go to IDLE.

Width rules and boundary conditions:
- Counters wrap modulo 2^`ITER_W`. They cannot overflow within one run, because each counter is at most `num_iters`.
- Counters and `out_is_local` hold their values in IDLE until the next start.
- `in_Pls` ≥ 100 gives always-local, because the draw never exceeds 100.
- `in_Pls`=0 gives local only when the draw is 0.
- `in_start` outside IDLE is ignored. Changes to `in_Pls` or `in_num_iters` during a run are ignored.
- `in_abort` has priority over every other transition in every state.
  - Next state is IDLE, with no `out_done` pulse and no start pulse.
  - Counters keep their partial values.
  - Any move already in flight is the owning unit's responsibility; its late done signal is ignored in IDLE.
- Done signals arriving in IDLE, DRAW, DECIDE or FINISH are ignored.
- A done signal in the same cycle as the start pulse is accepted.

## Timing
- Reset (`in_reset_n`=0 at an edge):
  - State becomes IDLE.
  - All outputs 0: `out_busy`, `out_done`, both start pulses, `out_rng_enable`, `out_is_local`, both counters.
  - Reset mid-run abandons the run without `out_done`.
- Start latency: `in_start` sampled at edge k.
  - DRAW during cycle k+1.
  - DECIDE during cycle k+2.
  - Start pulse during cycle k+3.
- Iteration cost: 2 + R cycles, where R is the number of RUN cycles including the done cycle (R ≥ 1).
- After the final done at edge d: `out_done` is high during cycle d+1, and `out_busy` is 0 from cycle d+2.
- All outputs are registered, or decoded from registered state with no input-to-output combinational path. Exception: none.

## Test plan
1. Reset with `in_reset_n`=0 for 2 cycles, outputs forced to X beforehand -> all outputs 0, state IDLE.
2. `num_iters`=4, `Pls`=50, RNG stub returns 10, 90, 50, 51, each done returned 3 cycles after its start -> start sequence L, G, L, G; `local_count`=2, `global_count`=2; `out_done` exactly once, 4×(2+4)+1 cycles after `in_start`.
3. `Pls`=200, `num_iters`=3, RNG returns 100 -> all three moves local; `local_count`=3.
4. `num_iters`=0 -> `out_done` in the cycle after start; no `out_rng_enable`; counters 0.
5. `in_abort` during RUN_G of iteration 2 of 5 -> IDLE next cycle; no `out_done`; `global_done` arriving later is ignored; a following `in_start` runs cleanly from counters 0.
6. Wrong-unit done (`in_global_done` during RUN_L), plus `in_start` and `in_Pls` change mid-run -> no state change and no new run; the decision keeps using the captured `Pls`.
